uni_reg_seq: RTL and testbench



---
 rtl/uni_reg_pkg.sv | 32 +++
 rtl/uni_reg_shift_cnt.sv | 40 ++++
 rtl/uni_reg_seq.sv | 163 ++++++++++++++++
 tb/tb_uni_reg_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uni_reg_pkg.sv
// -----------------------------------------------------------------------------
// uni_reg_pkg
// Shared definitions for the universal shift register and its upstream
// sequencer: register mode encodings, shift-direction encodings and the
// sequencer state type.
// -----------------------------------------------------------------------------
package uni_reg_pkg;

    // Register mode pin encodings
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Shift direction encodings (job field)
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Register mode used while shifting in the given direction
    function automatic logic [1:0] shift_mode(input logic dir);
        return (dir == DIR_DOWN) ? MODE_DOWN : MODE_UP;
    endfunction

endpackage

// File: rtl/uni_reg_shift_cnt.sv
// -----------------------------------------------------------------------------
// uni_reg_shift_cnt
// Loadable down-counter that tracks the remaining shift cycles of a job.
//
// Ports:
//   clk     in   clock, rising edge
//   clear   in   synchronous active-high reset
//   load    in   load counter with value
//   value   in   CW  count to load
//   dec     in   decrement by one (saturates at zero)
//   last_c  out  combinational: counter currently equals 1
// -----------------------------------------------------------------------------
module uni_reg_shift_cnt #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] value,
    input  logic          dec,
    output logic          last_c
);

    logic [CW-1:0] cnt;

    // Counter register; load wins over decrement
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Final shift cycle of the job
    assign last_c = (cnt == CW'(1));

endmodule

// File: rtl/uni_reg_seq.sv
// -----------------------------------------------------------------------------
// uni_reg_seq
// Upstream sequencer for the universal shift register. Accepts one job per
// valid/ready handshake and drives the register pins: one parallel-load
// cycle, 'count' shift cycles, then a one-cycle done pulse.
//
// Optional build macro: UNI_REG_SEQ_ROTATE_EN
//   defined   : in_fill acts as rotate-enable; serial inputs are taken from
//               the fed-back register output reg_q during SHIFT.
//   undefined : in_fill is the literal fill bit; reg_q is ignored.
//
// Ports:
//   clk          in   clock, rising edge
//   clear        in   synchronous active-high reset (shared with register)
//   in_valid     in   job offered
//   in_ready     out  job can be accepted (IDLE only)
//   in_data      in   WIDTH  word to parallel-load
//   in_dir       in   0 = shift up, 1 = shift down
//   in_count     in   CW     shift cycles after load
//   in_fill      in   fill bit (rotate-enable in rotate build)
//   reg_q        in   WIDTH  register output feedback
//   modo         out  2      register mode
//   entparalela  out  WIDTH  register parallel data
//   serder       out  serial input, low end
//   serizq       out  serial input, high end
//   busy         out  job in progress
//   done         out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module uni_reg_seq
    import uni_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [CW-1:0]    in_count,
    input  logic             in_fill,
    input  logic [WIDTH-1:0] reg_q,
    output logic [1:0]       modo,
    output logic [WIDTH-1:0] entparalela,
    output logic             serder,
    output logic             serizq,
    output logic             busy,
    output logic             done
);

    state_t        state;
    state_t        state_nxt;

    // Job registers (the job word lives in entparalela itself)
    logic          job_dir;
    logic          job_fill;
    logic [CW-1:0] job_count;

    // Next values of the registered outputs
    logic [1:0]    modo_nxt;
    logic          ser_lo_nxt;
    logic          ser_hi_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          ready_nxt;

    // Registered serial enables; gated by reg_q in the rotate build
    logic          ser_lo_en;
    logic          ser_hi_en;

    logic          accept_c;
    logic          cnt_last_c;

    assign accept_c = in_valid & in_ready;

    // Shift-cycle counter: loaded during LOAD, counts down through SHIFT
    uni_reg_shift_cnt #(
        .CW (CW)
    ) u_shift_cnt (
        .clk    (clk),
        .clear  (clear),
        .load   (state == LOAD),
        .value  (job_count),
        .dec    (state == SHIFT),
        .last_c (cnt_last_c)
    );

    // Next state and next registered outputs (decoded from next state)
    always_comb begin
        state_nxt  = state;
        modo_nxt   = MODE_HOLD;
        ser_lo_nxt = 1'b0;
        ser_hi_nxt = 1'b0;

        case (state)
            IDLE:    if (accept_c) state_nxt = LOAD;
            LOAD:    state_nxt = (job_count != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt_last_c) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Job fields are stable whenever the next state is SHIFT
        case (state_nxt)
            LOAD:    modo_nxt = MODE_LOAD;
            SHIFT: begin
                modo_nxt   = shift_mode(job_dir);
                ser_lo_nxt = job_fill & (job_dir == DIR_UP);
                ser_hi_nxt = job_fill & (job_dir == DIR_DOWN);
            end
            default: modo_nxt = MODE_HOLD;
        endcase

        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
        ready_nxt = (state_nxt == IDLE);
    end

    // State, job and output registers
    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= IDLE;
            job_dir     <= DIR_UP;
            job_fill    <= 1'b0;
            job_count   <= '0;
            entparalela <= '0;
            modo        <= MODE_HOLD;
            ser_lo_en   <= 1'b0;
            ser_hi_en   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            state     <= state_nxt;
            modo      <= modo_nxt;
            ser_lo_en <= ser_lo_nxt;
            ser_hi_en <= ser_hi_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            in_ready  <= ready_nxt;
            if (accept_c) begin
                job_dir     <= in_dir;
                job_fill    <= in_fill;
                job_count   <= in_count;
                entparalela <= in_data;
            end
        end
    end

`ifdef UNI_REG_SEQ_ROTATE_EN
    // Rotation: recirculate the bit leaving the opposite end of the register
    assign serder = ser_lo_en & reg_q[WIDTH-1];
    assign serizq = ser_hi_en & reg_q[0];
`else
    assign serder = ser_lo_en;
    assign serizq = ser_hi_en;

    logic unused_reg_q;
    assign unused_reg_q = ^reg_q;
`endif

endmodule

// File: tb/tb_uni_reg_seq.sv
// -----------------------------------------------------------------------------
// tb_uni_reg_seq
// Bench for uni_reg_seq driving a behavioural universal shift register.
// Expected register contents come from closed-form shift/rotate arithmetic.
// -----------------------------------------------------------------------------
module tb_uni_reg_seq;
    import uni_reg_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CW    = 3;
    localparam int          MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic [CW-1:0]    in_count;
    logic             in_fill;
    logic [WIDTH-1:0] reg_q;
    logic [1:0]       modo;
    logic [WIDTH-1:0] entparalela;
    logic             serder;
    logic             serizq;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uni_reg_seq #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dir      (in_dir),
        .in_count    (in_count),
        .in_fill     (in_fill),
        .reg_q       (reg_q),
        .modo        (modo),
        .entparalela (entparalela),
        .serder      (serder),
        .serizq      (serizq),
        .busy        (busy),
        .done        (done)
    );

    // Behavioural 4-bit universal shift register sharing clk/clear
    always_ff @(posedge clk) begin
        if (clear) reg_q <= '0;
        else begin
            case (modo)
                2'b01:   reg_q <= {reg_q[WIDTH-2:0], serder};
                2'b10:   reg_q <= {serizq, reg_q[WIDTH-1:1]};
                2'b11:   reg_q <= entparalela;
                default: reg_q <= reg_q;
            endcase
        end
    end

    // Final register value after load + count shifts, by plain arithmetic
    function automatic logic [WIDTH-1:0] model_q(input logic [WIDTH-1:0] data,
                                                 input logic dir, input int count,
                                                 input logic fill);
        int v;
        int f;
        int r;
        v = int'(data);
        f = fill ? 1 : 0;
`ifdef UNI_REG_SEQ_ROTATE_EN
        if (f != 0) begin
            r = count % WIDTH;
            if (r != 0) begin
                if (!dir) v = ((v << r) | (v >> (WIDTH - r))) & MASK;
                else      v = ((v >> r) | (v << (WIDTH - r))) & MASK;
            end
            return WIDTH'(v);
        end
        f = 0;
`else
        r = 0;
`endif
        if (!dir) v = ((v << count) | ((f != 0) ? ((1 << count) - 1) : 0)) & MASK;
        else      v = (v >> count) | ((f != 0) ? (MASK & ~(MASK >> count)) : 0);
        return WIDTH'(v + r * 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_count = '0; in_fill = 1'b0;
        clear = 1'b1;
        tick();
        tick();
        n_tests++;
        if (modo !== 2'b00) begin n_fail++; $display("FAIL reset_modo got %b want 00", modo); end
        n_tests++;
        if (entparalela !== 4'b0000) begin n_fail++; $display("FAIL reset_entparalela got %b want 0000", entparalela); end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++;
        if (serder !== 1'b0 || serizq !== 1'b0) begin n_fail++; $display("FAIL reset_serial got %b%b want 00", serder, serizq); end
        clear = 1'b0;
        tick();
    endtask

    // Offer one job and follow it cycle by cycle to the end of DONE
    task automatic run_job(input logic [WIDTH-1:0] data, input logic dir,
                           input int count, input logic fill, input string tag);
        int waited;
        logic [1:0] exp_mode;
        logic [WIDTH-1:0] exp_q;
        waited = 0;
        exp_mode = dir ? 2'b10 : 2'b01;
        exp_q = model_q(data, dir, count, fill);
        in_valid = 1'b1; in_data = data; in_dir = dir; in_count = CW'(count); in_fill = fill;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept_timeout in_ready=%b want 1", tag, in_ready);
            in_valid = 1'b0;
            return;
        end
        tick();
        // Fields scrambled mid-job must be ignored
        in_valid = 1'b0;
        in_data = WIDTH'($urandom); in_dir = 1'($urandom);
        in_count = CW'($urandom); in_fill = 1'($urandom);
        n_tests++;
        if (modo !== 2'b11 || entparalela !== data || busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s load_cycle modo=%b ent=%b busy=%b done=%b rdy=%b want modo=11 ent=%b busy=1 done=0 rdy=0",
                     tag, modo, entparalela, busy, done, in_ready, data);
        end
        for (int i = 0; i < count; i++) begin
            tick();
            n_tests++;
            if (modo !== exp_mode || done !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s shift_cycle%0d modo=%b done=%b busy=%b want modo=%b done=0 busy=1",
                         tag, i, modo, done, busy, exp_mode);
            end
`ifndef UNI_REG_SEQ_ROTATE_EN
            n_tests++;
            if (serder !== (!dir && fill) || serizq !== (dir && fill)) begin
                n_fail++;
                $display("FAIL %s serial_cycle%0d serder=%b serizq=%b want %b %b",
                         tag, i, serder, serizq, (!dir && fill), (dir && fill));
            end
`endif
        end
        tick();
        n_tests++;
        if (modo !== 2'b00 || done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_cycle modo=%b done=%b busy=%b want modo=00 done=1 busy=1", tag, modo, done, busy);
        end
        n_tests++;
        if (reg_q !== exp_q) begin
            n_fail++;
            $display("FAIL %s reg_q got %b want %b", tag, reg_q, exp_q);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || modo !== 2'b00 || entparalela !== data) begin
            n_fail++;
            $display("FAIL %s after_done done=%b busy=%b rdy=%b modo=%b ent=%b want 0 0 1 00 %b",
                     tag, done, busy, in_ready, modo, entparalela, data);
        end
    endtask

    task automatic test_directed();
        run_job(4'b1011, 1'b0, 2, 1'b0, "up2_fill0");
        run_job(4'b0110, 1'b1, 1, 1'b1, "down1_fill1");
        run_job(4'b1001, 1'b0, 0, 1'b0, "zero_count");
        run_job(4'b1000, 1'b0, 1, 1'b1, "fill_or_rotate");
        run_job(4'b0101, 1'b0, 7, 1'b1, "up7_overfill");
        run_job(4'b1010, 1'b1, 6, 1'b0, "down6_overfill");
    endtask

    task automatic test_back_to_back();
        int cyc;
        int done_cyc;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        d1 = 4'b0111;
        d2 = 4'b1101;
        in_valid = 1'b1; in_data = d1; in_dir = 1'b0; in_count = CW'(3); in_fill = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin tick(); cyc++; end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b accept_timeout in_ready=%b want 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        // cycle 0 is the first accept; second job is queued from cycle 1
        tick();
        in_data = d2; in_dir = 1'b1; in_count = CW'(5); in_fill = 1'b0;
        n_tests++;
        if (entparalela !== d1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b first_load ent=%b rdy=%b want %b 0", entparalela, in_ready, d1);
        end
        cyc = 1;
        done_cyc = -1;
        while (cyc < 15) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                n_tests++;
                if (reg_q !== model_q(d1, 1'b0, 3, 1'b1)) begin
                    n_fail++;
                    $display("FAIL b2b first_reg_q got %b want %b", reg_q, model_q(d1, 1'b0, 3, 1'b1));
                end
            end
            if (in_ready === 1'b1) break;
        end
        n_tests++;
        if (done_cyc != 5) begin n_fail++; $display("FAIL b2b first_done_cycle got %0d want 5", done_cyc); end
        n_tests++;
        if (cyc != 6) begin n_fail++; $display("FAIL b2b second_accept_cycle got %0d want 6", cyc); end
        tick();
        n_tests++;
        if (modo !== 2'b11 || entparalela !== d2) begin
            n_fail++;
            $display("FAIL b2b second_load modo=%b ent=%b want 11 %b", modo, entparalela, d2);
        end
        tick();
        tick();
        n_tests++;
        if (modo !== 2'b10) begin n_fail++; $display("FAIL b2b second_shift2 modo=%b want 10", modo); end
        // Clear during the second shift cycle of the second job
        clear = 1'b1;
        in_valid = 1'b0;
        tick();
        clear = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || modo !== 2'b00 || entparalela !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_clear outputs busy=%b done=%b rdy=%b modo=%b ent=%b want 0 0 1 00 0000",
                     busy, done, in_ready, modo, entparalela);
        end
        n_tests++;
        if (reg_q !== 4'b0000) begin n_fail++; $display("FAIL mid_clear reg_q got %b want 0000", reg_q); end
        done_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_cyc++;
        end
        n_tests++;
        if (done_cyc != 0) begin n_fail++; $display("FAIL mid_clear stray_activity got %0d want 0", done_cyc); end
    endtask

    task automatic test_random();
        int gap;
        for (int j = 0; j < 30; j++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            run_job(WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, (1 << CW) - 1)),
                    1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached want finish before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
